nfc_byte_packer: RTL and testbench



---
 rtl/nfc_byte_packer_if.sv | 47 ++++
 rtl/nfc_byte_packer.sv | 150 +++++++++++++++
 tb/tb_nfc_byte_packer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nfc_byte_packer_if.sv
// nfc_byte_packer_if
//   Bundles the byte-capture handshake, the page-RAM write port and the
//   transfer control/status signals of the NFC byte packer.
//
//   Signals:
//     start       transfer start pulse (driven by master)
//     xfer_len    transfer length in bytes, sampled on start (master)
//     byte_vld    captured byte valid (master)
//     byte_in     captured byte (master)
//     byte_rdy    packer can accept a byte (slave)
//     word_rd     consumer has read one word, frees one slot (master)
//     write       RAM byte-lane write enables, bit0 = [7:0] (slave)
//     addr_wr     RAM write address (slave)
//     data_in     RAM write data, byte replicated on both lanes (slave)
//     busy        transfer in progress (slave)
//     done        one-cycle end-of-transfer pulse (slave)
//     words_avail completed, unread words in the RAM (slave)
//
//   Modports: master = capture/control side, slave = the packer.
interface nfc_byte_packer_if #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 4,
    parameter int LEN_W = 6
);
    logic             start;
    logic [LEN_W-1:0] xfer_len;
    logic             byte_vld;
    logic [7:0]       byte_in;
    logic             byte_rdy;
    logic             word_rd;
    logic [1:0]       write;
    logic [ADDR-1:0]  addr_wr;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [ADDR:0]    words_avail;

    modport master (
        output start, xfer_len, byte_vld, byte_in, word_rd,
        input  byte_rdy, write, addr_wr, data_in, busy, done, words_avail
    );

    modport slave (
        input  start, xfer_len, byte_vld, byte_in, word_rd,
        output byte_rdy, write, addr_wr, data_in, busy, done, words_avail
    );
endinterface

// File: rtl/nfc_byte_packer.sv
// nfc_byte_packer
//   Write-side front end of the NFC page buffer. Packs the 8-bit NAND capture
//   stream into byte-lane writes of the 16-bit page RAM, one registered write
//   per accepted byte, keeps a circular word write pointer and a count of
//   completed unread words, and back-pressures capture when the RAM is full.
//
//   Ports:
//     clk    clock, also the RAM write clock
//     rst_n  synchronous active-low reset
//     bus    nfc_byte_packer_if.slave (start/xfer_len, byte handshake,
//            word_rd, RAM write port, busy/done/words_avail)
//
//   Build option:
//     NFC_PACK_SWAP_EN  when defined, the first byte of each word goes to
//                       lane [15:8] and the second to [7:0].
module nfc_byte_packer #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 4,
    parameter int DEPTH = 16,
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    nfc_byte_packer_if.slave bus
);

`ifdef NFC_PACK_SWAP_EN
    localparam logic LANE_SWAP = 1'b1;
`else
    localparam logic LANE_SWAP = 1'b0;
`endif

    localparam logic [ADDR:0] FULL = (ADDR+1)'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PACK = 1'b1
    } state_t;

    state_t           state_q,  state_d;
    logic [ADDR-1:0]  wr_ptr_q, wr_ptr_d;
    logic             lane_q,   lane_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic [ADDR:0]    words_q,  words_d;
    logic [1:0]       write_q,  write_d;
    logic [ADDR-1:0]  addr_q,   addr_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic             done_q,   done_d;

    logic byte_rdy;
    logic accept;
    logic last_byte;
    logic complete;
    logic rd_ok;

    // A lane-1 byte is always accepted: its word slot was reserved when the
    // lane-0 partner was let in, so only lane 0 looks at the fill level.
    assign byte_rdy  = (state_q == S_PACK) && (lane_q || (words_q < FULL));
    assign accept    = byte_rdy && bus.byte_vld;
    assign last_byte = (remain_q == LEN_W'(1));
    assign complete  = accept && (lane_q || last_byte);
    assign rd_ok     = bus.word_rd && (words_q != '0);

    // Stage 0 -> stage 1: accepted byte becomes a registered RAM write
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        lane_d   = lane_q;
        remain_d = remain_q;
        words_d  = words_q;
        write_d  = 2'b00;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.xfer_len != '0) begin
                        state_d  = S_PACK;
                        remain_d = bus.xfer_len;
                        lane_d   = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_PACK: begin
                if (accept) begin
                    write_d  = (lane_q ^ LANE_SWAP) ? 2'b10 : 2'b01;
                    addr_d   = wr_ptr_q;
                    data_d   = {2{bus.byte_in}};
                    lane_d   = ~lane_q;
                    remain_d = remain_q - LEN_W'(1);
                    // DEPTH == 2**ADDR, so the pointer wraps by overflow.
                    if (complete) begin
                        wr_ptr_d = wr_ptr_q + ADDR'(1);
                    end
                    // An odd transfer abandons the upper lane; the next
                    // transfer always begins on lane 0 of a fresh word.
                    if (last_byte) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                        lane_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        case ({complete, rd_ok})
            2'b10:   words_d = words_q + (ADDR+1)'(1);
            2'b01:   words_d = words_q - (ADDR+1)'(1);
            default: words_d = words_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            lane_q   <= 1'b0;
            remain_q <= '0;
            words_q  <= '0;
            write_q  <= 2'b00;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            lane_q   <= lane_d;
            remain_q <= remain_d;
            words_q  <= words_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    assign bus.byte_rdy    = byte_rdy;
    assign bus.write       = write_q;
    assign bus.addr_wr     = addr_q;
    assign bus.data_in     = data_q;
    assign bus.busy        = (state_q == S_PACK);
    assign bus.done        = done_q;
    assign bus.words_avail = words_q;

endmodule

// File: tb/tb_nfc_byte_packer.sv
// tb_nfc_byte_packer
//   Self-checking bench for nfc_byte_packer: a table of directed vectors for
//   the basic 4-byte transfer, hand-written sequences for the multi-cycle
//   corner cases, and randomized traffic checked against a transfer-level
//   reference model (byte index -> word offset / lane arithmetic).
module tb_nfc_byte_packer;
    localparam int WIDTH = 16;
    localparam int ADDR  = 4;
    localparam int DEPTH = 16;
    localparam int LEN_W = 6;

`ifdef NFC_PACK_SWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    nfc_byte_packer_if #(.WIDTH(WIDTH), .ADDR(ADDR), .LEN_W(LEN_W)) bus ();

    nfc_byte_packer #(
        .WIDTH(WIDTH), .ADDR(ADDR), .DEPTH(DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state, at transfer level.
    bit              m_known = 1'b0;
    bit              m_busy  = 1'b0;
    int              m_len   = 0;
    int              m_k     = 0;   // bytes accepted in current transfer
    int              m_base  = 0;   // first word index of current transfer
    int              m_avail = 0;
    logic [1:0]      m_write = 2'b00;
    logic [ADDR-1:0] m_addr  = '0;
    logic [15:0]     m_data  = '0;
    bit              m_done  = 1'b0;

    typedef struct {
        logic             st;
        logic [LEN_W-1:0] len;
        logic             vld;
        logic [7:0]       b;
        logic             rd;
        logic             rn;
        logic [1:0]       we;
        logic [ADDR-1:0]  addr;
        logic [15:0]      data;
        logic             done;
        logic             busy;
        logic [ADDR:0]    avail;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    endtask

    function automatic logic [1:0] sw(input logic [1:0] w);
        return SWAP ? {w[0], w[1]} : w;
    endfunction

    // Drives one clock of inputs, advances the model and compares outputs
    // one time unit after the rising edge.
    task automatic cycle(input bit st, input int len, input bit vld, input logic [7:0] b,
                         input bit rd, input bit rn);
        bit exp_rdy;
        bit acc;
        bit comp;
        int lane;
        bus.start    = st;
        bus.xfer_len = LEN_W'(len);
        bus.byte_vld = vld;
        bus.byte_in  = b;
        bus.word_rd  = rd;
        rst_n        = rn;
        exp_rdy = m_busy && (((m_k % 2) == 1) || (m_avail < DEPTH));
        if (m_known) check("byte_rdy", 32'(bus.byte_rdy), 32'(exp_rdy));
        m_write = 2'b00;
        m_done  = 1'b0;
        if (!rn) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_len   = 0;
            m_k     = 0;
            m_base  = 0;
            m_avail = 0;
            m_addr  = '0;
            m_data  = '0;
        end else begin
            acc  = m_busy && vld && exp_rdy;
            comp = 1'b0;
            if (acc) begin
                lane    = m_k % 2;
                m_write = ((lane == 1) ^ SWAP) ? 2'b10 : 2'b01;
                m_addr  = ADDR'((m_base + m_k / 2) % DEPTH);
                m_data  = {b, b};
                comp    = (lane == 1) || (m_k == m_len - 1);
                m_k++;
                if (m_k == m_len) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_base = (m_base + (m_len + 1) / 2) % DEPTH;
                end
            end else if (!m_busy && st) begin
                if (len == 0) m_done = 1'b1;
                else begin
                    m_busy = 1'b1;
                    m_len  = len;
                    m_k    = 0;
                end
            end
            if (comp && !(rd && m_avail > 0)) m_avail++;
            else if (!comp && rd && m_avail > 0) m_avail--;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (m_known) begin
            check("write", 32'(bus.write), 32'(m_write));
            check("done", 32'(bus.done), 32'(m_done));
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("words_avail", 32'(bus.words_avail), 32'(m_avail));
            if (m_write != 2'b00 || !rn) begin
                check("addr_wr", 32'(bus.addr_wr), 32'(m_addr));
                check("data_in", 32'(bus.data_in), 32'(m_data));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic give(input logic [7:0] b);
        cycle(1'b0, 0, 1'b1, b, 1'b0, 1'b1);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.xfer_len = '0;
        bus.byte_vld = 1'b0;
        bus.byte_in  = 8'h00;
        bus.word_rd  = 1'b0;
        rst_n        = 1'b0;

        //          st    len    vld   byte   rd    rn  |  we     addr  data      done  busy  avail
        tbl[0] = '{1'b0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 1'b0, 5'd0};
        tbl[1] = '{1'b0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 1'b0, 5'd0};
        tbl[2] = '{1'b1, 6'd4, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 4'd0, 16'h0000, 1'b0, 1'b1, 5'd0};
        tbl[3] = '{1'b0, 6'd0, 1'b1, 8'hA1, 1'b0, 1'b1, 2'b01, 4'd0, 16'hA1A1, 1'b0, 1'b1, 5'd0};
        tbl[4] = '{1'b0, 6'd0, 1'b1, 8'hB2, 1'b0, 1'b1, 2'b10, 4'd0, 16'hB2B2, 1'b0, 1'b1, 5'd1};
        tbl[5] = '{1'b0, 6'd0, 1'b1, 8'hC3, 1'b0, 1'b1, 2'b01, 4'd1, 16'hC3C3, 1'b0, 1'b1, 5'd1};
        tbl[6] = '{1'b0, 6'd0, 1'b1, 8'hD4, 1'b0, 1'b1, 2'b10, 4'd1, 16'hD4D4, 1'b1, 1'b0, 5'd2};
        tbl[7] = '{1'b0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 4'd0, 16'h0000, 1'b0, 1'b0, 5'd2};

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].st, int'(tbl[i].len), tbl[i].vld, tbl[i].b, tbl[i].rd, tbl[i].rn);
            check("tbl_write", 32'(bus.write), 32'(sw(tbl[i].we)));
            check("tbl_done", 32'(bus.done), 32'(tbl[i].done));
            check("tbl_busy", 32'(bus.busy), 32'(tbl[i].busy));
            check("tbl_avail", 32'(bus.words_avail), 32'(tbl[i].avail));
            if (tbl[i].we != 2'b00 || !tbl[i].rn) begin
                check("tbl_addr", 32'(bus.addr_wr), 32'(tbl[i].addr));
                check("tbl_data", 32'(bus.data_in), 32'(tbl[i].data));
            end
        end

        // Odd-length transfer followed by a second transfer.
        cycle(1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 3, 1'b0, 8'h00, 1'b0, 1'b1);
        give(8'h11);
        give(8'h22);
        give(8'h33);
        check("odd_last_addr", 32'(bus.addr_wr), 32'd1);
        check("odd_last_we", 32'(bus.write), 32'(sw(2'b01)));
        check("odd_done", 32'(bus.done), 32'd1);
        cycle(1'b1, 2, 1'b0, 8'h00, 1'b0, 1'b1);
        give(8'h44);
        check("next_xfer_addr", 32'(bus.addr_wr), 32'd2);
        check("next_xfer_we", 32'(bus.write), 32'(sw(2'b01)));
        give(8'h55);
        check("two_xfer_avail", 32'(bus.words_avail), 32'd3);

        // Fill to full, stall, free one slot, wrap to address 0.
        cycle(1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 34, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) give(8'(i + 8'h80));
        check("fill_last_addr", 32'(bus.addr_wr), 32'd15);
        check("fill_avail", 32'(bus.words_avail), 32'd16);
        check("full_rdy", 32'(bus.byte_rdy), 32'd0);
        give(8'hEE);
        give(8'hEE);
        cycle(1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("freed_rdy", 32'(bus.byte_rdy), 32'd1);
        give(8'h5A);
        check("wrap_addr", 32'(bus.addr_wr), 32'd0);
        check("wrap_we", 32'(bus.write), 32'(sw(2'b01)));
        give(8'h5B);
        check("wrap_done", 32'(bus.done), 32'd1);

        // word_rd coincident with completion, then word_rd on empty.
        cycle(1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b1, 2, 1'b0, 8'h00, 1'b0, 1'b1);
        give(8'h61);
        cycle(1'b0, 0, 1'b1, 8'h62, 1'b1, 1'b1);
        check("rd_and_complete", 32'(bus.words_avail), 32'd15);
        for (int i = 0; i < 17; i++) cycle(1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("rd_on_empty", 32'(bus.words_avail), 32'd0);

        // Reset in the middle of an 8-byte transfer.
        cycle(1'b1, 8, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) give(8'(8'h20 + i));
        cycle(1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_avail", 32'(bus.words_avail), 32'd0);
        check("mid_rst_addr", 32'(bus.addr_wr), 32'd0);
        cycle(1'b1, 2, 1'b0, 8'h00, 1'b0, 1'b1);
        give(8'h77);
        check("post_rst_addr", 32'(bus.addr_wr), 32'd0);
        check("post_rst_we", 32'(bus.write), 32'(sw(2'b01)));
        give(8'h78);

        // Zero-length start, then start pulses while busy.
        cycle(1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("zero_len_done", 32'(bus.done), 32'd1);
        check("zero_len_we", 32'(bus.write), 32'd0);
        idle(1);
        cycle(1'b1, 4, 1'b0, 8'h00, 1'b0, 1'b1);
        give(8'h91);
        cycle(1'b1, 10, 1'b1, 8'h92, 1'b0, 1'b1);
        cycle(1'b1, 9, 1'b0, 8'h00, 1'b0, 1'b1);
        give(8'h93);
        give(8'h94);
        check("busy_start_done", 32'(bus.done), 32'd1);
        check("busy_start_addr", 32'(bus.addr_wr), 32'd2);
        idle(1);
        check("busy_start_idle", 32'(bus.busy), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 40)),
                  $urandom_range(0, 9) < 7,
                  8'($urandom),
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 299) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
